// File: rtl/row_memory_sequencer_if.sv
// row_memory_sequencer_if
//  Bundles the 16-bit external SRAM port used by the row memory sequencer.
//  master : sequencer side (drives address, write data and the two enables,
//           receives read data)
//  slave  : SRAM side (the mirror image)
//  Signals:
//   memAddr     15  SRAM word address
//   memDataOut  16  write data toward the SRAM
//   memDataIn   16  read data from the SRAM, valid one cycle after the address
//                   was presented with memOe=1
//   memWe        1  write enable, one word per cycle
//   memOe        1  output (read) enable
interface row_memory_sequencer_if;
    logic [14:0] memAddr;
    logic [15:0] memDataOut;
    logic [15:0] memDataIn;
    logic        memWe;
    logic        memOe;

    modport master (
        output memAddr,
        output memDataOut,
        output memWe,
        output memOe,
        input  memDataIn
    );

    modport slave (
        input  memAddr,
        input  memDataOut,
        input  memWe,
        input  memOe,
        output memDataIn
    );
endinterface

// File: rtl/row_memory_sequencer.sv
// row_memory_sequencer
//  Once per display row, writes the calculator's 640-bit result back to the
//  SRAM row above the current one, then fetches the row below into readRow and
//  raises `reading`. A rowStart that arrives while a transfer is still running
//  is dropped and flagged on the sticky overrun output.
//  Ports:
//   clkDiv    in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   rowStart  in   one-cycle strobe at start of horizontal blank
//   row       in   current display row, sampled with rowStart
//   commit    in   1 = perform the write-back phase this row
//   writeRow  in   computed row, snapshotted with rowStart
//   readRow   out  fetched row, stable while reading=1
//   reading   out  fetch complete, cleared by the next accepted rowStart
//   busy      out  transfer in progress
//   overrun   out  sticky: rowStart seen while busy
//   mem       SRAM port (master side)
module row_memory_sequencer (
    input  logic                          clkDiv,
    input  logic                          rst,
    input  logic                          rowStart,
    input  logic [8:0]                    row,
    input  logic                          commit,
    input  logic [639:0]                  writeRow,
    output logic [639:0]                  readRow,
    output logic                          reading,
    output logic                          busy,
    output logic                          overrun,
    row_memory_sequencer_if.master        mem
);
    localparam logic [8:0] LAST_ROW  = 9'd479;
    localparam logic [5:0] LAST_WORD = 6'd39;
    localparam logic [5:0] READ_END  = 6'd40;

    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2, DONE = 2'd3} state_t;

    state_t        stateReg, stateNext;
    logic [5:0]    wordReg, wordNext, capIdx;
    logic [14:0]   wrBaseReg, wrBaseNext, rdBaseReg, rdBaseNext;
    logic [639:0]  snapReg, snapNext, readRowReg, readRowNext;
    logic          readingReg, readingNext, busyReg, busyNext, overrunReg, overrunNext;
    logic [14:0]   memAddrReg, memAddrNext;
    logic [15:0]   memDataOutReg, memDataOutNext;
    logic          memWeReg, memWeNext, memOeReg, memOeNext;
    logic [8:0]    wrIdx, rdIdx;
    logic [14:0]   wrIdxW, rdIdxW;
    logic          acceptStart;

    // Neighbouring rows with wrap at both ends of the stored frame.
    assign wrIdx  = (row == 9'd0) ? LAST_ROW : (row - 9'd1);
    assign rdIdx  = (row == LAST_ROW) ? 9'd0 : (row + 9'd1);
    assign wrIdxW = {6'd0, wrIdx};
    assign rdIdxW = {6'd0, rdIdx};

    // busy is still high in the first DONE cycle, so a strobe landing on DONE
    // entry counts as an overrun rather than a new transfer.
    assign acceptStart = rowStart && !busyReg && ((stateReg == IDLE) || (stateReg == DONE));

    // Next-state, datapath and next-cycle SRAM port values.
    always_comb begin
        stateNext   = stateReg;
        wordNext    = wordReg;
        wrBaseNext  = wrBaseReg;
        rdBaseNext  = rdBaseReg;
        snapNext    = snapReg;
        readRowNext = readRowReg;
        readingNext = readingReg;
        busyNext    = busyReg;
        overrunNext = overrunReg | (rowStart & busyReg);
        capIdx      = wordReg - 6'd1;

        case (stateReg)
            IDLE, DONE: begin
                if (stateReg == DONE) begin
                    readingNext = 1'b1;
                    busyNext    = 1'b0;
                end else begin
                    readingNext = readingReg;
                end
                if (acceptStart) begin
                    // idx*40 as two shifts and an add
                    wrBaseNext  = (wrIdxW << 5) + (wrIdxW << 3);
                    rdBaseNext  = (rdIdxW << 5) + (rdIdxW << 3);
                    snapNext    = writeRow;
                    readingNext = 1'b0;
                    busyNext    = 1'b1;
                    wordNext    = 6'd0;
                    stateNext   = commit ? WRITE : READ;
                end else begin
                    stateNext   = stateReg;
                end
            end
            WRITE: begin
                if (wordReg == LAST_WORD) begin
                    wordNext  = 6'd0;
                    stateNext = READ;
                end else begin
                    wordNext  = wordReg + 6'd1;
                end
            end
            READ: begin
                // Data returned this cycle belongs to the address issued last cycle.
                if (wordReg != 6'd0) begin
                    readRowNext[{capIdx, 4'd0} +: 16] = mem.memDataIn;
                end else begin
                    readRowNext = readRowReg;
                end
                if (wordReg == READ_END) begin
                    wordNext  = 6'd0;
                    stateNext = DONE;
                end else begin
                    wordNext  = wordReg + 6'd1;
                end
            end
            default: begin
                stateNext = IDLE;
                wordNext  = 6'd0;
            end
        endcase

        // Port values are registered, so derive them from the upcoming state.
        memWeNext      = 1'b0;
        memOeNext      = 1'b0;
        memAddrNext    = 15'd0;
        memDataOutNext = 16'd0;
        case (stateNext)
            WRITE: begin
                memWeNext      = 1'b1;
                memAddrNext    = wrBaseNext + {9'd0, wordNext};
                memDataOutNext = snapNext[{wordNext, 4'd0} +: 16];
            end
            READ: begin
                // The final READ cycle only collects the last word.
                if (wordNext != READ_END) begin
                    memOeNext   = 1'b1;
                    memAddrNext = rdBaseNext + {9'd0, wordNext};
                end else begin
                    memOeNext   = 1'b0;
                end
            end
            default: begin
                memWeNext = 1'b0;
                memOeNext = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops the SRAM enables immediately.
    always_ff @(posedge clkDiv or posedge rst) begin
        if (rst) begin
            stateReg      <= IDLE;
            wordReg       <= 6'd0;
            wrBaseReg     <= 15'd0;
            rdBaseReg     <= 15'd0;
            snapReg       <= 640'd0;
            readRowReg    <= 640'd0;
            readingReg    <= 1'b0;
            busyReg       <= 1'b0;
            overrunReg    <= 1'b0;
            memAddrReg    <= 15'd0;
            memDataOutReg <= 16'd0;
            memWeReg      <= 1'b0;
            memOeReg      <= 1'b0;
        end else begin
            stateReg      <= stateNext;
            wordReg       <= wordNext;
            wrBaseReg     <= wrBaseNext;
            rdBaseReg     <= rdBaseNext;
            snapReg       <= snapNext;
            readRowReg    <= readRowNext;
            readingReg    <= readingNext;
            busyReg       <= busyNext;
            overrunReg    <= overrunNext;
            memAddrReg    <= memAddrNext;
            memDataOutReg <= memDataOutNext;
            memWeReg      <= memWeNext;
            memOeReg      <= memOeNext;
        end
    end

    assign readRow        = readRowReg;
    assign reading        = readingReg;
    assign busy           = busyReg;
    assign overrun        = overrunReg;
    assign mem.memAddr    = memAddrReg;
    assign mem.memDataOut = memDataOutReg;
    assign mem.memWe      = memWeReg;
    assign mem.memOe      = memOeReg;
endmodule

// File: tb/tb_row_memory_sequencer.sv
module tb_row_memory_sequencer;
    logic         clkDiv = 1'b0;
    logic         rst = 1'b1;
    logic         rowStart = 1'b0;
    logic [8:0]   row = 9'd0;
    logic         commit = 1'b0;
    logic [639:0] writeRow = 640'd0;
    logic [639:0] readRow;
    logic         reading;
    logic         busy;
    logic         overrun;

    row_memory_sequencer_if memIf();

    row_memory_sequencer dut (
        .clkDiv   (clkDiv),
        .rst      (rst),
        .rowStart (rowStart),
        .row      (row),
        .commit   (commit),
        .writeRow (writeRow),
        .readRow  (readRow),
        .reading  (reading),
        .busy     (busy),
        .overrun  (overrun),
        .mem      (memIf)
    );

    always #5 clkDiv = ~clkDiv;

    typedef struct packed {
        logic        isWr;
        logic [14:0] addr;
        logic [15:0] data;
    } txn_t;

    txn_t        expQ[$];
    txn_t        monTxn;
    logic [15:0] sram [0:19199];
    int          tests = 0;
    int          fails = 0;

    // Preload: row 6 (240..279) is 0xA5A5, everything else a per-address pattern.
    function automatic logic [15:0] initWord(input int a);
        if (a >= 240 && a < 280) return 16'hA5A5;
        return 16'(a) ^ 16'h3C00;
    endfunction

    function automatic logic [639:0] expRow(input int rIdx);
        logic [639:0] r;
        for (int i = 0; i < 40; i++) r[16*i +: 16] = initWord(rIdx * 40 + i);
        return r;
    endfunction

    function automatic logic [639:0] mkRow(input logic [15:0] seed);
        logic [639:0] r;
        for (int i = 0; i < 40; i++) r[16*i +: 16] = seed + 16'(i * 273);
        return r;
    endfunction

    // SRAM model: synchronous write, read data one cycle after the address.
    always @(posedge clkDiv) begin
        if (memIf.memWe) sram[memIf.memAddr] <= memIf.memDataOut;
        if (memIf.memOe) memIf.memDataIn <= sram[memIf.memAddr];
    end

    // Monitor: every bus access must match the next expected transaction.
    always @(negedge clkDiv) begin
        if (memIf.memWe && memIf.memOe) begin
            tests++;
            fails++;
            $display("FAIL weOeOverlap: got we=1 oe=1 at addr %0d, required never both high", memIf.memAddr);
        end else if (memIf.memWe || memIf.memOe) begin
            tests++;
            if (expQ.size() == 0) begin
                fails++;
                $display("FAIL unexpectedAccess: got we=%0b oe=%0b addr=%0d, required no access",
                         memIf.memWe, memIf.memOe, memIf.memAddr);
            end else begin
                monTxn = expQ.pop_front();
                if (monTxn.isWr !== memIf.memWe || monTxn.addr !== memIf.memAddr ||
                    (monTxn.isWr && monTxn.data !== memIf.memDataOut)) begin
                    fails++;
                    $display("FAIL memTxn: got we=%0b addr=%0d data=%04h, required we=%0b addr=%0d data=%04h",
                             memIf.memWe, memIf.memAddr, memIf.memDataOut,
                             monTxn.isWr, monTxn.addr, monTxn.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic checkRow(input string name, input logic [639:0] act, input logic [639:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic checkIdleReset(input string tag);
        check({tag, "_reading"}, reading, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_memWe"}, memIf.memWe, 0);
        check({tag, "_memOe"}, memIf.memOe, 0);
        check({tag, "_memAddr"}, memIf.memAddr, 0);
        check({tag, "_memDataOut"}, memIf.memDataOut, 0);
        checkRow({tag, "_readRow"}, readRow, 640'd0);
    endtask

    // One row transaction; optional stray rowStart (glitchAt) or reset (abortAt).
    task automatic runRow(input int r, input bit cm, input logic [15:0] seed,
                          input int glitchAt, input int abortAt);
        int           wr, rd, cycles;
        logic [639:0] wd;
        txn_t         t;
        wr = (r == 0) ? 479 : r - 1;
        rd = (r == 479) ? 0 : r + 1;
        wd = mkRow(seed);
        if (cm) begin
            for (int i = 0; i < 40; i++) begin
                t.isWr = 1'b1; t.addr = 15'(wr * 40 + i); t.data = wd[16*i +: 16];
                expQ.push_back(t);
            end
        end
        for (int i = 0; i < 40; i++) begin
            t.isWr = 1'b0; t.addr = 15'(rd * 40 + i); t.data = 16'd0;
            expQ.push_back(t);
        end
        @(negedge clkDiv);
        rowStart = 1'b1; row = 9'(r); commit = cm; writeRow = wd;
        @(posedge clkDiv); #1;
        rowStart = 1'b0;
        check("acceptBusy", busy, 1);
        check("acceptReadingLow", reading, 0);
        cycles = 0;
        while (!reading && cycles < 200) begin
            @(posedge clkDiv); cycles++; #1;
            if (cycles == glitchAt) begin
                rowStart = 1'b1; row = 9'd300; commit = 1'b0; writeRow = mkRow(16'hDEAD);
                @(posedge clkDiv); cycles++; #1;
                rowStart = 1'b0;
                check("overrunSet", overrun, 1);
                check("busyAfterStray", busy, 1);
            end
            if (cycles == abortAt) begin
                check("abortInRead", memIf.memOe, 1);
                rst = 1'b1; #1;
                check("abortOe", memIf.memOe, 0);
                check("abortWe", memIf.memWe, 0);
                check("abortReading", reading, 0);
                check("abortBusy", busy, 0);
                expQ.delete();
                @(negedge clkDiv);
                rst = 1'b0;
                return;
            end
        end
        check("latency", cycles, cm ? 82 : 42);
        checkRow("readRow", readRow, expRow(rd));
        check("queueDrained", expQ.size(), 0);
        check("doneBusyLow", busy, 0);
    endtask

    initial begin
        for (int a = 0; a < 19200; a++) sram[a] = initWord(a);
        memIf.memDataIn = 16'd0;
        rst = 1'b1;
        repeat (3) @(posedge clkDiv);
        #1;
        checkIdleReset("reset");
        @(negedge clkDiv);
        rst = 1'b0;

        runRow(5, 1'b1, 16'h1234, -1, -1);     // write 160..199, read row 6 (0xA5A5)
        check("overrunClear", overrun, 0);
        runRow(0, 1'b1, 16'h4000, -1, -1);     // write row 479 (19160..19199)
        runRow(479, 1'b1, 16'h7777, -1, -1);   // read wraps to row 0
        runRow(10, 1'b0, 16'h0000, -1, -1);    // no write phase, reads 440..479
        runRow(100, 1'b1, 16'hBEEF, 20, -1);   // stray rowStart during WRITE
        check("overrunSticky", overrun, 1);
        runRow(200, 1'b1, 16'h5555, -1, 50);   // reset mid-READ
        #1;
        checkIdleReset("afterAbort");
        runRow(7, 1'b1, 16'h0F0F, -1, -1);     // clean transfer after abort
        repeat (3) @(posedge clkDiv);
        #1;
        check("finalQueueEmpty", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
